// File: rtl/rptr_empty_mon_if.sv
// Read-side FIFO pointer bus: request/clear and synchronised write pointer in,
// read pointer, address and status flags out.
interface rptr_empty_mon_if #(
  parameter int unsigned ADDRSIZE = 4
) ();

  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rerr_clr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                rerr;

  // Driver side (read-domain consumer)
  modport master (
    output rinc, rq2_wptr, rerr_clr,
    input  raddr, rptr, rempty, raempty, rlevel, rerr
  );

  // Pointer/empty block side
  modport slave (
    input  rinc, rq2_wptr, rerr_clr,
    output raddr, rptr, rempty, raempty, rlevel, rerr
  );

endinterface

// File: rtl/rptr_empty_mon.sv
// Async FIFO read-side pointer and empty-flag block.
// Keeps a binary read pointer plus its registered Gray copy, raises a registered
// empty flag that already accounts for this cycle's pop, and holds a sticky
// underflow flag. Define RPTR_AEMPTY_EN to build the fill-level and
// almost-empty registers; otherwise raempty follows rempty and rlevel reads 0.
module rptr_empty_mon #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input logic              i_rclk,
  input logic              i_rrst,
  rptr_empty_mon_if.slave  io_bus
);

  localparam int unsigned PtrW = ADDRSIZE + 1;

  if (AE_THRESH >= (1 << ADDRSIZE)) begin : g_bad_thresh
    $error("AE_THRESH must be below the FIFO depth");
  end

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic              r_rerr;

  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic              w_pop;
  logic              w_underflow;
  logic              w_rempty_next;

  // A pop needs a request and a non-empty FIFO; a request while empty is an underflow.
  assign w_pop         = io_bus.rinc & ~r_rempty;
  assign w_underflow   = io_bus.rinc & r_rempty;
  assign w_rbinnext    = r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
  assign w_rgraynext   = (w_rbinnext >> 1) ^ w_rbinnext;
  // Compared against the post-pop pointer so the last pop and empty land together.
  assign w_rempty_next = (w_rgraynext == io_bus.rq2_wptr);

  // Binary/Gray read pointers and empty flag.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbinnext;
      r_rptr   <= w_rgraynext;
      r_rempty <= w_rempty_next;
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      r_rerr <= 1'b0;
    end else if (w_underflow) begin
      r_rerr <= 1'b1;
    end else if (io_bus.rerr_clr) begin
      r_rerr <= 1'b0;
    end
  end

  assign io_bus.raddr  = r_rbin[ADDRSIZE-1:0];
  assign io_bus.rptr   = r_rptr;
  assign io_bus.rempty = r_rempty;
  assign io_bus.rerr   = r_rerr;

`ifdef RPTR_AEMPTY_EN
  localparam logic [ADDRSIZE:0] AeThresh = PtrW'(AE_THRESH);

  logic [ADDRSIZE:0] w_rq2_wbin;
  logic [ADDRSIZE:0] w_rlevel_next;
  logic [ADDRSIZE:0] r_rlevel;
  logic              r_raempty;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rq2_wbin = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      w_rq2_wbin[i] = ^(io_bus.rq2_wptr >> i);
    end
  end

  // Modulo subtraction keeps the level right across pointer wrap.
  assign w_rlevel_next = w_rq2_wbin - w_rbinnext;

  // Fill level and almost-empty, timed like the empty flag.
  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      r_rlevel  <= '0;
      r_raempty <= 1'b1;
    end else begin
      r_rlevel  <= w_rlevel_next;
      r_raempty <= (w_rlevel_next <= AeThresh);
    end
  end

  assign io_bus.rlevel  = r_rlevel;
  assign io_bus.raempty = r_raempty;
`else
  assign io_bus.rlevel  = '0;
  assign io_bus.raempty = r_rempty;
`endif

endmodule

// File: tb/tb_rptr_empty_mon.sv
// Bench for rptr_empty_mon: directed fill/drain, underflow, full, wrap and reset
// cases plus a randomized run, all compared each cycle against a count-based model.
module tb_rptr_empty_mon;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          AET   = 2;

  logic clk;
  logic rrst;

  rptr_empty_mon_if #(.ADDRSIZE(AW)) u_if ();

  rptr_empty_mon #(
    .ADDRSIZE  (AW),
    .AE_THRESH (AET)
  ) u_dut (
    .i_rclk (clk),
    .i_rrst (rrst),
    .io_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: total words written (as seen through the synchroniser) and popped.
  int m_w     = 0;
  int m_r     = 0;
  bit m_empty = 1'b1;
  bit m_err   = 1'b0;

  // Literal expectations for directed steps; -1 means don't care.
  int lit_rempty  = -1;
  int lit_raempty = -1;
  int lit_rptr    = -1;
  int lit_raddr   = -1;
  int lit_rlevel  = -1;
  int lit_rerr    = -1;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic int lvl_exp(input int lvl);
`ifdef RPTR_AEMPTY_EN
    return lvl;
`else
    return 0;
`endif
  endfunction

  function automatic int ae_exp(input int lvl, input bit empty);
`ifdef RPTR_AEMPTY_EN
    return (lvl <= AET) ? 1 : 0;
`else
    return int'(empty);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: model and any literal expectations, on every falling edge.
  logic [4:0] prev_rptr = '0;
  bit         prev_ok   = 1'b0;
  always @(negedge clk) begin
    int lvl;
    lvl = m_w - m_r;
    chk("rempty",  int'(u_if.rempty),  int'(m_empty));
    chk("rptr",    int'(u_if.rptr),    int'(gray(m_r)));
    chk("raddr",   int'(u_if.raddr),   m_r % DEPTH);
    chk("rlevel",  int'(u_if.rlevel),  lvl_exp(lvl));
    chk("raempty", int'(u_if.raempty), ae_exp(lvl, m_empty));
    chk("rerr",    int'(u_if.rerr),    int'(m_err));
    if (lit_rempty  >= 0) chk("lit_rempty",  int'(u_if.rempty),  lit_rempty);
    if (lit_raempty >= 0) chk("lit_raempty", int'(u_if.raempty), lit_raempty);
    if (lit_rptr    >= 0) chk("lit_rptr",    int'(u_if.rptr),    lit_rptr);
    if (lit_raddr   >= 0) chk("lit_raddr",   int'(u_if.raddr),   lit_raddr);
    if (lit_rlevel  >= 0) chk("lit_rlevel",  int'(u_if.rlevel),  lit_rlevel);
    if (lit_rerr    >= 0) chk("lit_rerr",    int'(u_if.rerr),    lit_rerr);
    if (rrst) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) chk("rptr_gray_step", int'($countones(u_if.rptr ^ prev_rptr) <= 1), 1);
      prev_rptr = u_if.rptr;
      prev_ok   = 1'b1;
    end
  end

  // Apply one cycle of inputs, then advance the model across the rising edge.
  task automatic tick(input bit rinc, input int w, input bit clr);
    bit pop;
    u_if.rinc     = rinc;
    u_if.rq2_wptr = gray(w);
    u_if.rerr_clr = clr;
    @(posedge clk);
    if (!rrst) begin
      pop = rinc && !m_empty;
      if (rinc && m_empty) m_err = 1'b1;
      else if (clr)        m_err = 1'b0;
      if (pop) m_r++;
      m_w     = w;
      m_empty = (m_w == m_r);
    end
    #1;
  endtask

  task automatic expect_lit(input int em, input int ae, input int ptr, input int addr,
                            input int lvl, input int err);
    lit_rempty  = em;
    lit_raempty = ae;
    lit_rptr    = ptr;
    lit_raddr   = addr;
    lit_rlevel  = lvl;
    lit_rerr    = err;
    @(negedge clk);
    #1;
    lit_rempty  = -1;
    lit_raempty = -1;
    lit_rptr    = -1;
    lit_raddr   = -1;
    lit_rlevel  = -1;
    lit_rerr    = -1;
  endtask

  // Async reset asserted between rising edges with a read pending; outputs must
  // already be at reset values on the next falling edge.
  task automatic do_reset();
    u_if.rinc     = 1'b1;
    u_if.rq2_wptr = '0;
    u_if.rerr_clr = 1'b0;
    rrst          = 1'b1;
    m_w = 0; m_r = 0; m_empty = 1'b1; m_err = 1'b0;
    expect_lit(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    u_if.rinc = 1'b0;
    rrst      = 1'b0;
  endtask

  int lvl_tab[5] = '{4, 3, 2, 1, 0};
  int ae_tab[5]  = '{0, 0, 1, 1, 1};
  int em_tab[5]  = '{0, 0, 0, 0, 1};

  initial begin
    int w;
    bit rd;
    rrst          = 1'b1;
    u_if.rinc     = 1'b0;
    u_if.rq2_wptr = '0;
    u_if.rerr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rrst = 1'b0;

    // Fill to 5, then drain.
    tick(1'b0, 5, 1'b0);
    expect_lit(0, 0, 0, 0, lvl_exp(5), 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 5, 1'b0);
`ifdef RPTR_AEMPTY_EN
      expect_lit(em_tab[i], ae_tab[i], -1, i + 1, lvl_tab[i], 0);
`else
      expect_lit(em_tab[i], em_tab[i], -1, i + 1, 0, 0);
`endif
    end

    // Underflow: pointers hold at Gray(5) = 5'b00111, error sticks.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 5, 1'b0);
      expect_lit(1, 1, 7, 5, 0, 1);
    end
    tick(1'b1, 5, 1'b1);
    expect_lit(1, 1, 7, 5, 0, 1);
    tick(1'b0, 5, 1'b1);
    expect_lit(1, 1, 7, 5, 0, 0);

    // Reset from a non-zero state, then jump straight to a full FIFO (Gray 5'b11000).
    do_reset();
    tick(1'b0, 16, 1'b0);
    expect_lit(0, 0, 0, 0, lvl_exp(16), 0);

    // Wrap: one write and one pop per cycle at level 1.
    do_reset();
    tick(1'b0, 1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 2 + i, 1'b0);
      expect_lit(0, ae_exp(1, 1'b0), -1, (i + 1) % DEPTH, lvl_exp(1), 0);
    end

    // Randomized run; write side advances at most one step per cycle.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2500) do_reset();
      w = m_w;
      if ((m_w - m_r) < DEPTH && ($urandom_range(0, 3) < ((i % 1000) < 400 ? 3 : 1))) w++;
      rd = ($urandom_range(0, 3) < ((i % 1000) < 400 ? 1 : 3));
      tick(rd, w, ($urandom_range(0, 15) == 0));
    end

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rptr_empty_mon.md
Name: rptr_empty_mon

Overview:
Read-side pointer and empty-flag block for the async FIFO, the read-domain counterpart of the write-pointer/full logic. It advances a binary read pointer and its Gray-coded copy, addresses the dual-port RAM, and raises registered empty. It also derives a registered fill level and almost-empty flag from the two-flop-synchronised write pointer, and keeps a sticky underflow error flag.

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
AE_THRESH, 2, almost-empty asserts when level <= AE_THRESH; legal range 0..2^ADDRSIZE-1.

Ports:
rclk  input  1  read-domain clock; all logic on rising edge.
rrst  input  1  asynchronous, active-high reset; asserts immediately, releases synchronously to rclk (release synchroniser lives upstream).
rinc  input  1  read request; a pop occurs only when rinc=1 and rempty=0.
rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already two-flop synchronised into rclk.
rerr_clr  input  1  clears the sticky underflow flag.
raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0].
rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write-domain synchroniser.
rempty  output  1  registered empty flag.
raempty  output  1  registered almost-empty flag.
rlevel  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
rerr  output  1  sticky underflow flag.

Behaviour:
- Reset (rrst=1, async): rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, rerr=0.
- rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1), so the pointer wraps naturally.
- rgraynext = (rbinnext>>1) ^ rbinnext.
- On each rclk edge: rbin<=rbinnext; rptr<=rgraynext.
- rptr is driven only from a flop: no combinational path to the output.
- rempty <= (rgraynext == rq2_wptr).
- The empty flag reflects the state after this cycle's pop, so the last word pops and rempty rises on the same edge. There is no extra bubble.
- Empty removal is pessimistic. When a write lands, rempty deasserts one rclk after rq2_wptr changes, which is the synchroniser latency plus one cycle.
- Gray-to-binary conversion: rq2_wbin[ADDRSIZE]=rq2_wptr[ADDRSIZE]; rq2_wbin[i]=rq2_wbin[i+1]^rq2_wptr[i]. Purely combinational.
- rlevel <= (rq2_wbin - rbinnext) mod 2^(ADDRSIZE+1).
  - Maximum value is 2^ADDRSIZE (full); it never exceeds this for legal input.
  - rlevel==0 exactly when rempty_val.
- Underflow: rinc=1 while rempty=1 sets rerr on that edge and does not move the pointers.
- rerr holds until rerr_clr=1. If rerr_clr and a new underflow occur on the same edge, set wins and rerr stays 1.
- Wrap-around: after 2^(ADDRSIZE+1) pops, rbin returns to 0 and rptr MSB toggles twice. Empty/level comparisons remain correct across the wrap.
- Simultaneous write visibility and pop in the same cycle: both are reflected. For example, rlevel stays unchanged if one word arrives and one is popped.
- Reset mid-operation: all flops return to reset values within the same cycle.
  - The write side must be reset together with the read side.
  - A read-only reset is not supported and its outputs are undefined until both sides are reset.

Optional Feature:
RPTR_AEMPTY_EN.
- Defined: the rq2_wbin conversion, rlevel register and raempty register are built.
  - raempty <= (rlevel_next <= AE_THRESH), with the same timing as rempty.
  - rempty implies raempty.
- Undefined: the conversion and registers are omitted; raempty is tied to rempty and rlevel is tied to 0.
- Ports are identical in both builds.

Test Plan:
1. Reset check (ADDRSIZE=4): assert rrst mid-clock with rinc=1 -> rempty=1, raempty=1, rptr=0, raddr=0, rlevel=0, rerr=0 immediately, without waiting for an rclk edge.
2. Fill then drain:
   - Set rq2_wptr=Gray(5)=5'b00111 and hold rinc=0 -> after 1 rclk, rempty=0, rlevel=5, raempty=0.
   - Then pulse rinc for 5 cycles -> raddr goes 0..4; rlevel goes 4,3,2,1,0; raempty rises when rlevel=2; rempty=1 on the edge of the 5th pop.
3. Underflow: with rempty=1, rinc=1 for 3 cycles -> rptr unchanged, rerr=1 after the first edge.
   - Assert rerr_clr together with rinc=1 -> rerr stays 1.
   - Assert rerr_clr alone -> rerr=0 next edge.
4. Full level: rq2_wptr=Gray(16)=5'b11000 with rbin=0 -> rlevel=16, rempty=0, raempty=0.
5. Wrap: stream 40 writes and reads keeping level at 1 -> rbin wraps 31->0, raddr wraps 15->0, rempty never asserts, no rerr.
   - Each step of rptr changes exactly one bit; check this with an assertion.
6. Macro off (RPTR_AEMPTY_EN undefined): repeat test 2 -> rempty timing is identical, raempty==rempty every cycle, rlevel=0 throughout.
